// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
// Holds the FSM encoding, legal oversampling ratios and parity helpers.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic [5:0] PS_8  = 6'd8;
  localparam logic [5:0] PS_16 = 6'd16;
  localparam logic [5:0] PS_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Unsupported ratios fall back to 8 so the edge counter always has a sane wrap point.
  function automatic logic [5:0] legal_ps(input logic [5:0] ps);
    case (ps)
      PS_8, PS_16, PS_32: legal_ps = ps;
      default:            legal_ps = PS_8;
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par_expect(input logic acc, input logic typ);
    return acc ^ (typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-tap capture around the bit centre and 2-of-3 majority vote.
// The vote is registered on the third tap edge and held until the next bit's vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] edge_cnt,
  input  logic [5:0] ps_q,
  input  logic       rx_in,
  output logic       sampled_bit
);

  logic [5:0] half;
  logic       tap0;
  logic       tap1;

  assign half = ps_q >> 1;

  // Third tap is used directly from rx_in so the vote lands one cycle earlier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap0        <= 1'b0;
      tap1        <= 1'b0;
      sampled_bit <= 1'b0;
    end else begin
      if (edge_cnt == half - 6'd1) tap0 <= rx_in;
      if (edge_cnt == half)        tap1 <= rx_in;
      if (edge_cnt == half + 6'd1) sampled_bit <= maj3(tap0, tap1, rx_in);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive front end: edge/bit counting, parity accumulation and frame sequencing.
// Drives the downstream deserializer with one deser_en strobe per data bit.
//
//  state  | meaning
//  IDLE   | line idle, waiting for a falling edge
//  START  | qualifying the start bit (glitch rejection)
//  DATA   | receiving WIDTH data bits, LSB first
//  PARITY | checking the optional parity bit
//  STOP   | checking the stop bit, issuing success
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic       par_en,
  input  logic       par_typ,
  output logic       sampled_bit,
  output logic       deser_en,
  output logic       success,
  output logic       par_err,
  output logic       stp_err,
  output logic       busy
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  rx_state_e      state;
  rx_state_e      state_nxt;
  logic [5:0]     edge_cnt;
  logic [5:0]     edge_nxt;
  logic [5:0]     ps_q;
  logic [5:0]     ps_nxt;
  logic [BCW-1:0] bit_cnt;
  logic [BCW-1:0] bit_nxt;
  logic           par_acc;
  logic           acc_nxt;
  logic           par_err_nxt;
  logic           stp_err_nxt;
  logic           at_d;

  assign at_d = (edge_cnt == ps_q - 6'd1);
  assign busy = (state != IDLE);

  uart_rx_sampler u_sampler (
    .clk         (clk),
    .rst         (rst),
    .edge_cnt    (edge_cnt),
    .ps_q        (ps_q),
    .rx_in       (rx_in),
    .sampled_bit (sampled_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      edge_cnt <= 6'd0;
      ps_q     <= PS_8;
      bit_cnt  <= '0;
      par_acc  <= 1'b0;
      par_err  <= 1'b0;
      stp_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      edge_cnt <= edge_nxt;
      ps_q     <= ps_nxt;
      bit_cnt  <= bit_nxt;
      par_acc  <= acc_nxt;
      par_err  <= par_err_nxt;
      stp_err  <= stp_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ps_nxt      = ps_q;
    bit_nxt     = bit_cnt;
    acc_nxt     = par_acc;
    par_err_nxt = par_err;
    stp_err_nxt = stp_err;
    deser_en    = 1'b0;
    success     = 1'b0;
    edge_nxt    = (state == IDLE || at_d) ? 6'd0 : edge_cnt + 6'd1;

    case (state)
      IDLE: begin
        // Error flags stay visible after a frame and are cleared only when the next one begins.
        if (!rx_in) begin
          state_nxt   = START;
          ps_nxt      = legal_ps(prescale);
          acc_nxt     = 1'b0;
          par_err_nxt = 1'b0;
          stp_err_nxt = 1'b0;
        end
      end
      START: begin
        if (at_d) begin
          if (!sampled_bit) begin
            state_nxt = DATA;
            bit_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (at_d) begin
          deser_en = 1'b1;
          acc_nxt  = par_acc ^ sampled_bit;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = par_en ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (at_d) begin
          if (sampled_bit != par_expect(par_acc, par_typ)) par_err_nxt = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (at_d) begin
          if (!sampled_bit) stp_err_nxt = 1'b1;
          success   = sampled_bit && !par_err && !stp_err;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames are driven bit-by-bit at the oversampling rate
// and strobes are collected by a negedge monitor, then compared against hand-derived values.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       sampled_bit;
  logic       deser_en;
  logic       success;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  int         cyc = 0;
  int         deser_cnt = 0;
  int         succ_cnt = 0;
  int         succ_cyc = 0;
  int         both_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  int         start_cyc = 0;

  int d0, s0;

  uart_rx_ctrl #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .sampled_bit (sampled_bit),
    .deser_en    (deser_en),
    .success     (success),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (deser_en) begin
        deser_cnt <= deser_cnt + 1;
        rx_byte   <= {sampled_bit, rx_byte[7:1]};
      end
      if (success) begin
        succ_cnt <= succ_cnt + 1;
        succ_cyc <= cyc;
      end
      if (deser_en && success) both_cnt <= both_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  // Drives one frame; cycle 0 is the first low cycle. abort_at >= 0 stops driving early.
  task automatic send(input logic [7:0] data, input int ps, input logic pb_en,
                      input logic pb, input logic stop_bit, input logic glitch,
                      input logic [5:0] ps_mid, input int abort_at);
    int total;
    int b;
    logic v;
    total = (10 + int'(pb_en)) * ps;
    for (int c = 0; c < total; c++) begin
      if (abort_at >= 0 && c == abort_at) return;
      @(negedge clk);
      b = c / ps;
      if (b == 0)                  v = 1'b0;
      else if (b <= 8)             v = data[b-1];
      else if (b == 9 && pb_en)    v = pb;
      else                         v = stop_bit;
      if (glitch && b >= 1 && b <= 8 && (c % ps) == ps / 2 + 1) v = ~v;
      rx_in = v;
      if (c == 0) start_cyc = cyc;
      if (c == 1) prescale = ps_mid;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_deser_en", 32'(deser_en), 32'd0);
    chk("rst_success", 32'(success), 32'd0);
    chk("rst_errs", 32'({par_err, stp_err}), 32'd0);
    chk("rst_sampled", 32'(sampled_bit), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(5);

    // 1: ps=8, 0xA5, mid-frame prescale change ignored
    prescale = PS_8; par_en = 1'b0;
    d0 = deser_cnt; s0 = succ_cnt;
    send(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, PS_16, -1);
    idle(4);
    chk("t1_deser_cnt", 32'(deser_cnt - d0), 32'd8);
    chk("t1_byte", 32'(rx_byte), 32'h0A5);
    chk("t1_success_cnt", 32'(succ_cnt - s0), 32'd1);
    chk("t1_success_cycle", 32'(succ_cyc - start_cyc), 32'd80);
    chk("t1_errs", 32'({par_err, stp_err}), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // 1b: illegal prescale falls back to 8
    prescale = 6'd20;
    d0 = deser_cnt; s0 = succ_cnt;
    send(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 6'd20, -1);
    idle(4);
    chk("t1b_byte", 32'(rx_byte), 32'h03C);
    chk("t1b_success_cycle", 32'(succ_cyc - start_cyc), 32'd80);
    chk("t1b_success_cnt", 32'(succ_cnt - s0), 32'd1);

    // 2: ps=16 with parity
    prescale = PS_16; par_en = 1'b1; par_typ = PAR_EVEN;
    s0 = succ_cnt;
    send(8'h03, 16, 1'b1, 1'b0, 1'b1, 1'b0, PS_16, -1);
    idle(4);
    chk("t2_byte", 32'(rx_byte), 32'h003);
    chk("t2_success_cnt", 32'(succ_cnt - s0), 32'd1);
    chk("t2_success_cycle", 32'(succ_cyc - start_cyc), 32'd176);
    chk("t2_par_err", 32'(par_err), 32'd0);
    s0 = succ_cnt;
    send(8'h03, 16, 1'b1, 1'b1, 1'b1, 1'b0, PS_16, -1);
    idle(4);
    chk("t2b_par_err", 32'(par_err), 32'd1);
    chk("t2b_success_cnt", 32'(succ_cnt - s0), 32'd0);
    par_typ = PAR_ODD;
    s0 = succ_cnt;
    send(8'h03, 16, 1'b1, 1'b1, 1'b1, 1'b0, PS_16, -1);
    idle(4);
    chk("t2c_par_err", 32'(par_err), 32'd0);
    chk("t2c_success_cnt", 32'(succ_cnt - s0), 32'd1);

    // 3: ps=32, bad stop bit, then next frame clears stp_err at its start
    prescale = PS_32; par_en = 1'b0; par_typ = PAR_EVEN;
    s0 = succ_cnt;
    send(8'h7E, 32, 1'b0, 1'b0, 1'b0, 1'b0, PS_32, -1);
    idle(4);
    chk("t3_stp_err", 32'(stp_err), 32'd1);
    chk("t3_success_cnt", 32'(succ_cnt - s0), 32'd0);
    chk("t3_byte", 32'(rx_byte), 32'h07E);
    send(8'h7E, 32, 1'b0, 1'b0, 1'b1, 1'b0, PS_32, 40);
    #1;
    chk("t3b_stp_err_cleared", 32'(stp_err), 32'd0);
    chk("t3b_busy", 32'(busy), 32'd1);
    idle(340);

    // 4: 3-cycle low glitch at ps=16
    prescale = PS_16;
    d0 = deser_cnt; s0 = succ_cnt;
    @(negedge clk); rx_in = 1'b0;
    @(negedge clk); rx_in = 1'b0;
    @(negedge clk); rx_in = 1'b0;
    idle(3);
    #1;
    chk("t4_busy_start", 32'(busy), 32'd1);
    idle(20);
    chk("t4_busy_drop", 32'(busy), 32'd0);
    chk("t4_deser_cnt", 32'(deser_cnt - d0), 32'd0);
    chk("t4_success_cnt", 32'(succ_cnt - s0), 32'd0);
    chk("t4_errs", 32'({par_err, stp_err}), 32'd0);

    // 5: centre-sample glitch on every data bit
    d0 = deser_cnt; s0 = succ_cnt;
    send(8'h96, 16, 1'b0, 1'b0, 1'b1, 1'b1, PS_16, -1);
    idle(4);
    chk("t5_byte", 32'(rx_byte), 32'h096);
    chk("t5_deser_cnt", 32'(deser_cnt - d0), 32'd8);
    chk("t5_success_cnt", 32'(succ_cnt - s0), 32'd1);

    // 6: back-to-back frames at ps=8
    prescale = PS_8;
    d0 = deser_cnt; s0 = succ_cnt;
    send(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, PS_8, -1);
    send(8'hAA, 8, 1'b0, 1'b0, 1'b1, 1'b0, PS_8, -1);
    idle(6);
    chk("t6_success_cnt", 32'(succ_cnt - s0), 32'd2);
    chk("t6_deser_cnt", 32'(deser_cnt - d0), 32'd16);
    chk("t6_byte", 32'(rx_byte), 32'h0AA);

    // 6b: reset asserted mid-way through the second of two frames
    s0 = succ_cnt;
    send(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, PS_8, -1);
    send(8'hAA, 8, 1'b0, 1'b0, 1'b1, 1'b0, PS_8, 40);
    #1;
    chk("t6b_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6b_rst_outputs",
        32'({sampled_bit, deser_en, success, par_err, stp_err, busy}), 32'd0);
    chk("t6b_success_first", 32'(succ_cnt - s0), 32'd1);
    idle(3);
    rst = 1'b1;
    idle(100);
    chk("t6b_no_second_success", 32'(succ_cnt - s0), 32'd1);
    chk("t6b_busy_after", 32'(busy), 32'd0);

    chk("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
